// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - time-multiplexed multi-lead FIR engine sharing one signed MAC
// One frame in, NUM_LEADS*KERNEL_SIZE MAC cycles, one saturated filtered frame out.
module fir_mac_sequencer #(
    parameter int DATA_RESOLUTION = 8,
    parameter int NUM_LEADS       = 3,
    parameter int KERNEL_SIZE     = 40,
    parameter int COEFF           = 1,
    parameter int KERNEL_SHIFT    = 10
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic [NUM_LEADS-1:0][DATA_RESOLUTION-1:0]     signed_data_in,
    input  logic                                          data_valid_in,
    output logic                                          ready_out,
    output logic [NUM_LEADS-1:0][DATA_RESOLUTION-1:0]     signed_data_out,
    output logic                                          data_valid_out,
    output logic                                          busy_out,
    output logic                                          overrun_out
);

    localparam int DR     = DATA_RESOLUTION;
    localparam int PROD_W = 2 * DR;
    localparam int ACC_W  = PROD_W + $clog2(KERNEL_SIZE);
    localparam int PTR_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int LEAD_W = (NUM_LEADS > 1) ? $clog2(NUM_LEADS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_MAC    = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam logic signed [DR-1:0]    C_COEFF = COEFF[DR-1:0];
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DR - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              r_state;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_tap;
    logic [LEAD_W-1:0]       r_lead;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DR-1:0]    r_hist [NUM_LEADS][KERNEL_SIZE];
    logic [DR-1:0]           r_result [NUM_LEADS];
    logic [NUM_LEADS-1:0][DR-1:0] r_data_out;
    logic                    r_valid_out;
    logic                    r_overrun;

    logic signed [DR-1:0]     w_sample;
    logic signed [PROD_W-1:0] w_product;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [ACC_W-1:0]  w_shifted;
    logic [DR-1:0]            w_sat;
    logic                     w_last_tap;
    logic                     w_last_lead;
    logic [PTR_W-1:0]         w_rd_prev;
    logic [PTR_W-1:0]         w_wr_next;

    // rd_ptr walks backwards from the newest sample, so it always equals (wr_ptr - tap) mod K.
    assign w_sample    = r_hist[r_lead][r_rd_ptr];
    assign w_product   = PROD_W'(w_sample) * PROD_W'(C_COEFF);
    assign w_acc_next  = r_acc + ACC_W'(w_product);
    assign w_shifted   = w_acc_next >>> KERNEL_SHIFT;
    assign w_last_tap  = (r_tap == PTR_W'(KERNEL_SIZE - 1));
    assign w_last_lead = (r_lead == LEAD_W'(NUM_LEADS - 1));
    assign w_rd_prev   = (r_rd_ptr == '0) ? PTR_W'(KERNEL_SIZE - 1) : r_rd_ptr - PTR_W'(1);
    assign w_wr_next   = (r_wr_ptr == PTR_W'(KERNEL_SIZE - 1)) ? '0 : r_wr_ptr + PTR_W'(1);

    always_comb begin
        w_sat = w_shifted[DR-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[DR-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[DR-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tap       <= '0;
            r_lead      <= '0;
            r_acc       <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overrun   <= 1'b0;
            for (int l = 0; l < NUM_LEADS; l++) begin
                r_result[l] <= '0;
                for (int k = 0; k < KERNEL_SIZE; k++) begin
                    r_hist[l][k] <= '0;
                end
            end
        end else begin
            r_valid_out <= 1'b0;
            if (data_valid_in && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (data_valid_in) begin
                        for (int l = 0; l < NUM_LEADS; l++) begin
                            r_hist[l][r_wr_ptr] <= signed_data_in[l];
                        end
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_acc    <= '0;
                    r_lead   <= '0;
                    r_tap    <= '0;
                    r_rd_ptr <= r_wr_ptr;
                    r_state  <= ST_MAC;
                end
                ST_MAC: begin
                    if (w_last_tap) begin
                        r_result[r_lead] <= w_sat;
                        r_acc    <= '0;
                        r_tap    <= '0;
                        r_rd_ptr <= r_wr_ptr;
                        if (w_last_lead) begin
                            // Publish during the FINISH cycle so the pulse and data coincide.
                            for (int l = 0; l < NUM_LEADS; l++) begin
                                r_data_out[l] <= r_result[l];
                            end
                            r_data_out[NUM_LEADS-1] <= w_sat;
                            r_valid_out <= 1'b1;
                            r_state     <= ST_FINISH;
                        end else begin
                            r_lead <= r_lead + LEAD_W'(1);
                        end
                    end else begin
                        r_acc    <= w_acc_next;
                        r_tap    <= r_tap + PTR_W'(1);
                        r_rd_ptr <= w_rd_prev;
                    end
                end
                ST_FINISH: begin
                    r_wr_ptr <= w_wr_next;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out       = (r_state == ST_IDLE);
    assign busy_out        = ~ready_out;
    assign signed_data_out = r_data_out;
    assign data_valid_out  = r_valid_out;
    assign overrun_out     = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - scoreboard bench for fir_mac_sequencer
// Three instances: defaults, KERNEL_SHIFT=0, and KERNEL_SIZE=4 with KERNEL_SHIFT=0.
module tb_fir_mac_sequencer;

    typedef logic [2:0][7:0] frame_t;

    logic   clk;
    logic   rst;
    frame_t din;
    logic   vin  [3];
    frame_t dout [3];
    logic   vout [3];
    logic   rdy  [3];
    logic   busy [3];
    logic   ovr  [3];

    int checks;
    int errors;

    int mh [3][3][40];
    int mptr [3];
    int ks [3] = '{40, 40, 4};
    int sh [3] = '{10, 0, 0};
    frame_t q [$];

    fir_mac_sequencer dut0 (
        .clk_in(clk), .rst_in(rst), .signed_data_in(din), .data_valid_in(vin[0]),
        .ready_out(rdy[0]), .signed_data_out(dout[0]), .data_valid_out(vout[0]),
        .busy_out(busy[0]), .overrun_out(ovr[0])
    );

    fir_mac_sequencer #(.KERNEL_SHIFT(0)) dut_s0 (
        .clk_in(clk), .rst_in(rst), .signed_data_in(din), .data_valid_in(vin[1]),
        .ready_out(rdy[1]), .signed_data_out(dout[1]), .data_valid_out(vout[1]),
        .busy_out(busy[1]), .overrun_out(ovr[1])
    );

    fir_mac_sequencer #(.KERNEL_SIZE(4), .KERNEL_SHIFT(0)) dut_k4 (
        .clk_in(clk), .rst_in(rst), .signed_data_in(din), .data_valid_in(vin[2]),
        .ready_out(rdy[2]), .signed_data_out(dout[2]), .data_valid_out(vout[2]),
        .busy_out(busy[2]), .overrun_out(ovr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            mptr[d] = 0;
            for (int l = 0; l < 3; l++)
                for (int k = 0; k < 40; k++) mh[d][l][k] = 0;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) vin[d] = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    task automatic send(input int sel, input int a0, input int a1, input int a2, output frame_t got);
        frame_t exp;
        int v [3];
        int s;
        int n;
        v[0] = a0; v[1] = a1; v[2] = a2;
        for (int l = 0; l < 3; l++) begin
            mh[sel][l][mptr[sel]] = v[l];
            s = 0;
            for (int k = 0; k < ks[sel]; k++) s += mh[sel][l][k] * 1;
            s = s >>> sh[sel];
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            exp[l] = s[7:0];
        end
        mptr[sel] = (mptr[sel] + 1) % ks[sel];
        q.push_back(exp);
        @(posedge clk); #1;
        din[0] = a0[7:0]; din[1] = a1[7:0]; din[2] = a2[7:0];
        vin[sel] = 1'b1;
        @(posedge clk); #1;
        vin[sel] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vout[sel] && n < 300);
        exp = q.pop_front();
        got = dout[sel];
        checks++;
        if (!vout[sel]) begin
            errors++;
            $display("FAIL send_timeout dut=%0d: no data_valid_out within %0d cycles", sel, n);
        end else begin
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (dout[sel][l] !== exp[l]) begin
                    errors++;
                    $display("FAIL scoreboard dut=%0d lead=%0d: got %0d expected %0d",
                             sel, l, $signed(dout[sel][l]), $signed(exp[l]));
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b1 || busy[d] !== 1'b0 || vout[d] !== 1'b0 ||
                ovr[d] !== 1'b0 || dout[d] !== '0) begin
                errors++;
                $display("FAIL reset_state dut=%0d: rdy=%b busy=%b vout=%b ovr=%b dout=%h expected 1 0 0 0 000000",
                         d, rdy[d], busy[d], vout[d], ovr[d], dout[d]);
            end
        end
    endtask

    task automatic test_pos_window();
        frame_t got;
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            send(0, 100, 100, 100, got);
            if (i == 11 || i == 31 || i == 40) begin
                for (int l = 0; l < 3; l++) begin
                    checks++;
                    if ($signed(got[l]) !== ((i == 11) ? 1 : 3)) begin
                        errors++;
                        $display("FAIL pos_window out=%0d lead=%0d: got %0d expected %0d",
                                 i, l, $signed(got[l]), (i == 11) ? 1 : 3);
                    end
                end
            end
        end
    endtask

    task automatic test_neg_shift();
        frame_t got;
        for (int i = 1; i <= 40; i++) send(0, -100, -100, -100, got);
        for (int l = 0; l < 3; l++) begin
            checks++;
            if ($signed(got[l]) !== -4) begin
                errors++;
                $display("FAIL neg_shift lead=%0d: got %0d expected -4", l, $signed(got[l]));
            end
        end
    endtask

    task automatic test_saturation();
        frame_t got;
        do_reset();
        for (int i = 1; i <= 40; i++) send(1, 100, -100, 0, got);
        checks++;
        if ($signed(got[0]) !== 127 || $signed(got[1]) !== -128 || $signed(got[2]) !== 0) begin
            errors++;
            $display("FAIL saturation: got %0d %0d %0d expected 127 -128 0",
                     $signed(got[0]), $signed(got[1]), $signed(got[2]));
        end
    endtask

    task automatic test_latency();
        frame_t e;
        e[0] = 8'd50; e[1] = 8'hCE; e[2] = 8'd7;
        do_reset();
        @(posedge clk); #1;
        din = e;
        vin[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL latency_ready_c0: got %b expected 1", rdy[1]);
        end
        for (int n = 1; n <= 126; n++) begin
            @(posedge clk); #1;
            vin[1] = 1'b0;
            @(negedge clk);
            checks++;
            if (vout[1] !== (n == 122) || rdy[1] !== (n >= 123) || busy[1] !== (n < 123)) begin
                errors++;
                $display("FAIL latency cycle=%0d: vout=%b rdy=%b busy=%b expected %b %b %b",
                         n, vout[1], rdy[1], busy[1], n == 122, n >= 123, n < 123);
            end
            if (n == 122) begin
                checks++;
                if (dout[1] !== e) begin
                    errors++;
                    $display("FAIL latency_data: got %h expected %h", dout[1], e);
                end
            end
        end
    endtask

    task automatic test_overrun();
        frame_t e;
        e[0] = 8'd50; e[1] = 8'hCE; e[2] = 8'd7;
        do_reset();
        @(posedge clk); #1;
        din = e;
        vin[1] = 1'b1;
        for (int n = 1; n <= 126; n++) begin
            @(posedge clk); #1;
            vin[1] = (n == 50);
            if (n == 50) din = '1;
            @(negedge clk);
            checks++;
            if (ovr[1] !== (n >= 51) || vout[1] !== (n == 122)) begin
                errors++;
                $display("FAIL overrun cycle=%0d: ovr=%b vout=%b expected %b %b",
                         n, ovr[1], vout[1], n >= 51, n == 122);
            end
            if (n == 122) begin
                checks++;
                if (dout[1] !== e) begin
                    errors++;
                    $display("FAIL overrun_data: got %h expected %h", dout[1], e);
                end
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (ovr[1] !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b expected 1", ovr[1]);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if (ovr[1] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", ovr[1]);
        end
    endtask

    task automatic test_ramp();
        frame_t got;
        do_reset();
        for (int i = 1; i <= 45; i++) begin
            send(2, i, 0, 0, got);
            if (i == 4 || i == 45) begin
                checks++;
                if ($signed(got[0]) !== ((i == 4) ? 10 : 127)) begin
                    errors++;
                    $display("FAIL ramp_k4 out=%0d: got %0d expected %0d",
                             i, $signed(got[0]), (i == 4) ? 10 : 127);
                end
            end
        end
        for (int i = 1; i <= 45; i++) send(1, i, 0, 0, got);
        checks++;
        if ($signed(got[0]) !== 127) begin
            errors++;
            $display("FAIL ramp_k40: got %0d expected 127", $signed(got[0]));
        end
    endtask

    task automatic test_reset_mid();
        frame_t got;
        int seen;
        do_reset();
        for (int i = 1; i <= 5; i++) send(1, 20, 20, 20, got);
        @(posedge clk); #1;
        din[0] = 8'd30; din[1] = 8'd30; din[2] = 8'd30;
        vin[1] = 1'b1;
        @(posedge clk); #1;
        vin[1] = 1'b0;
        repeat (59) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (vout[1]) seen++;
        end
        checks++;
        if (seen != 0 || dout[1] !== '0 || rdy[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: pulses=%0d dout=%h rdy=%b expected 0 000000 1", seen, dout[1], rdy[1]);
        end
        send(1, 7, -7, 0, got);
        checks++;
        if ($signed(got[0]) !== 7 || $signed(got[1]) !== -7 || $signed(got[2]) !== 0) begin
            errors++;
            $display("FAIL reset_mid_fresh: got %0d %0d %0d expected 7 -7 0",
                     $signed(got[0]), $signed(got[1]), $signed(got[2]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        din = '0;
        for (int d = 0; d < 3; d++) vin[d] = 1'b0;
        model_clear();
        test_reset();
        test_pos_window();
        test_neg_shift();
        test_saturation();
        test_latency();
        test_overrun();
        test_ramp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
